// File: rtl/ex_alu_pkg.sv
// Shared opcodes, skid FSM states and the buffered entry layout for the EX ALU stage.
package ex_alu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned SHAMT_W = $clog2(XLEN);
    localparam int unsigned RD_W    = 5;
    localparam int unsigned OP_W    = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_SLL = 3'b100;
    localparam logic [OP_W-1:0] OP_SLT = 3'b101;
    localparam logic [OP_W-1:0] OP_SRL = 3'b110;
    localparam logic [OP_W-1:0] OP_SRA = 3'b111;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            zero;
        logic [RD_W-1:0] rd;
        logic            illegal;
    } entry_t;

endpackage

// File: rtl/ex_alu_stage_if.sv
// Issue-side and EX/MEM-side valid/ready handshake of the EX ALU stage.
interface ex_alu_stage_if;
    import ex_alu_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] in_operation;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [RD_W-1:0] in_rd;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_zero;
    logic [RD_W-1:0] out_rd;
    logic            out_illegal;

    modport master (
        output in_valid, in_operation, in_a, in_b, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_rd, out_illegal
    );

    modport slave (
        input  in_valid, in_operation, in_a, in_b, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_rd, out_illegal
    );

endinterface

// File: rtl/ex_alu_stage_alu_core.sv
// Combinational ALU datapath; shifts exist only when ALU_SHIFT_EN is defined.
module alu_core
    import ex_alu_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            OP_ADD: result = a + b;
            OP_SUB: result = a - b;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_SLT: result = XLEN'($signed(a) < $signed(b));
`ifdef ALU_SHIFT_EN
            OP_SLL: result = a << b[SHAMT_W-1:0];
            OP_SRL: result = a >> b[SHAMT_W-1:0];
            OP_SRA: result = XLEN'($signed(a) >>> b[SHAMT_W-1:0]);
`endif
            default: begin
                result  = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ex_alu_stage.sv
// EX stage: ALU result captured at accept into a 2-entry skid (out + skid registers).
// Optional shifter enabled by defining ALU_SHIFT_EN.
module ex_alu_stage
    import ex_alu_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    ex_alu_stage_if.slave  bus
);

    state_t          state;
    entry_t          out_q;
    entry_t          skid_q;
    logic            out_valid_q;
    logic            in_ready_q;
    entry_t          new_entry;
    logic [XLEN-1:0] alu_result;
    logic            alu_illegal;
    logic            in_fire;
    logic            out_fire;

    alu_core u_alu (
        .op      (bus.in_operation),
        .a       (bus.in_a),
        .b       (bus.in_b),
        .result  (alu_result),
        .illegal (alu_illegal)
    );

    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid_q & bus.out_ready;

    always_comb begin
        new_entry.result  = alu_result;
        new_entry.zero    = (alu_result == '0);
        new_entry.rd      = bus.in_rd;
        new_entry.illegal = alu_illegal;
    end

    // Skid FSM; out_valid/in_ready are registered alongside the state they decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (flush) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        out_q       <= new_entry;
                        state       <= ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        out_q <= new_entry;
                    end else if (in_fire) begin
                        skid_q     <= new_entry;
                        state      <= FULL;
                        in_ready_q <= 1'b0;
                    end else if (out_fire) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        out_q      <= skid_q;
                        state      <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_result  = out_q.result;
    assign bus.out_zero    = out_q.zero;
    assign bus.out_rd      = out_q.rd;
    assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Randomized and directed bench for ex_alu_stage against a queue-based reference model.
module tb_ex_alu_stage;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic [4:0]  rd;
        logic        illegal;
    } exp_t;

    logic clk;
    logic rst_n;
    logic flush;
    int   n_tests;
    int   n_fail;
    exp_t q[$];

    ex_alu_stage_if bus ();

    ex_alu_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ref_entry(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [4:0] rd);
        exp_t e;
        int   sa;
        int   sb;
        int   sh;
        sa = a;
        sb = b;
        sh = int'(b[4:0]);
        e.rd      = rd;
        e.illegal = 1'b0;
        e.result  = 32'd0;
        case (op)
            3'b000: e.result = a + b;
            3'b001: e.result = a - b;
            3'b010: e.result = a & b;
            3'b011: e.result = a | b;
            3'b101: e.result = (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_EN
            3'b100: e.result = a << sh;
            3'b110: e.result = a >> sh;
            3'b111: e.result = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
`endif
            default: begin
                e.result  = 32'd0;
                e.illegal = 1'b1;
            end
        endcase
        e.zero = (e.result == 32'd0);
        return e;
    endfunction

    // One clock: drive at negedge, update model at posedge, compare at next negedge.
    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic ordy,
                        input logic fl, input logic rn);
        bit inf;
        bit outf;
        bus.in_valid     = v;
        bus.in_operation = op;
        bus.in_a         = a;
        bus.in_b         = b;
        bus.in_rd        = rd;
        bus.out_ready    = ordy;
        flush            = fl;
        rst_n            = rn;
        inf  = v && (q.size() < 2);
        outf = (q.size() > 0) && ordy;
        @(posedge clk);
        if (!rn || fl) begin
            q.delete();
        end else begin
            if (outf) void'(q.pop_front());
            if (inf) q.push_back(ref_entry(op, a, b, rd));
        end
        @(negedge clk);
        chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_result", bus.out_result, q[0].result);
            chk("out_zero", 32'(bus.out_zero), 32'(q[0].zero));
            chk("out_rd", 32'(bus.out_rd), 32'(q[0].rd));
            chk("out_illegal", 32'(bus.out_illegal), 32'(q[0].illegal));
        end
        if (!rn) begin
            chk("rst_result", bus.out_result, 32'd0);
            chk("rst_zero", 32'(bus.out_zero), 32'd0);
            chk("rst_rd", 32'(bus.out_rd), 32'd0);
            chk("rst_illegal", 32'(bus.out_illegal), 32'd0);
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 3'b000, 32'd0, 32'd0, 5'd0, ordy, 1'b0, 1'b1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        flush   = 1'b0;
        bus.in_valid = 1'b0; bus.in_operation = 3'b0; bus.in_a = '0; bus.in_b = '0;
        bus.in_rd = '0; bus.out_ready = 1'b0;
        @(negedge clk);

        // Reset held for two edges
        step(1'b0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_out_result", bus.out_result, 32'd0);

        // Streaming, one per cycle
        step(1'b1, 3'b000, 32'd5, 32'd7, 5'd1, 1'b1, 1'b0, 1'b1);
        chk("add", bus.out_result, 32'd12);
        step(1'b1, 3'b001, 32'd3, 32'd3, 5'd2, 1'b1, 1'b0, 1'b1);
        chk("sub", bus.out_result, 32'd0);
        chk("sub_zero", 32'(bus.out_zero), 32'd1);
        step(1'b1, 3'b010, 32'hF0, 32'h3C, 5'd3, 1'b1, 1'b0, 1'b1);
        chk("and", bus.out_result, 32'h30);
        step(1'b1, 3'b011, 32'hF0, 32'h0F, 5'd4, 1'b1, 1'b0, 1'b1);
        chk("or", bus.out_result, 32'hFF);
        step(1'b1, 3'b101, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1, 1'b0, 1'b1);
        chk("slt", bus.out_result, 32'd1);
        chk("slt_rd", 32'(bus.out_rd), 32'd5);
        idle(1'b1);

        // Backpressure
        step(1'b1, 3'b000, 32'd1, 32'd1, 5'd6, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'b000, 32'd2, 32'd2, 5'd7, 1'b0, 1'b0, 1'b1);
        chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
        step(1'b1, 3'b000, 32'd3, 32'd3, 5'd8, 1'b0, 1'b0, 1'b1);
        chk("bp_hold", bus.out_result, 32'd2);
        step(1'b1, 3'b000, 32'd3, 32'd3, 5'd8, 1'b1, 1'b0, 1'b1);
        chk("bp_second", bus.out_result, 32'd4);
        step(1'b1, 3'b000, 32'd3, 32'd3, 5'd8, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        chk("bp_third", bus.out_result, 32'd6);
        idle(1'b1);

        // Flush while FULL with a simultaneous accept
        step(1'b1, 3'b000, 32'd10, 32'd0, 5'd9, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'b000, 32'd11, 32'd0, 5'd10, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'b000, 32'd12, 32'd0, 5'd11, 1'b0, 1'b1, 1'b1);
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_ready", 32'(bus.in_ready), 32'd1);
        repeat (3) idle(1'b1);

        // Shift opcode, build dependent
        step(1'b1, 3'b100, 32'd1, 32'd4, 5'd12, 1'b1, 1'b0, 1'b1);
`ifdef ALU_SHIFT_EN
        chk("sll", bus.out_result, 32'd16);
        chk("sll_illegal", 32'(bus.out_illegal), 32'd0);
        step(1'b1, 3'b111, 32'h8000_0000, 32'd4, 5'd13, 1'b1, 1'b0, 1'b1);
        chk("sra", bus.out_result, 32'hF800_0000);
`else
        chk("op100_result", bus.out_result, 32'd0);
        chk("op100_illegal", 32'(bus.out_illegal), 32'd1);
        chk("op100_zero", 32'(bus.out_zero), 32'd1);
`endif

        // Wraparound
        step(1'b1, 3'b000, 32'hFFFF_FFFF, 32'd1, 5'd14, 1'b1, 1'b0, 1'b1);
        chk("add_wrap", bus.out_result, 32'd0);
        chk("add_wrap_zero", 32'(bus.out_zero), 32'd1);
        step(1'b1, 3'b001, 32'd0, 32'd1, 5'd15, 1'b1, 1'b0, 1'b1);
        chk("sub_wrap", bus.out_result, 32'hFFFF_FFFF);

        // Reset mid-operation while FULL
        step(1'b1, 3'b011, 32'h55, 32'hAA, 5'd16, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'b011, 32'h11, 32'h22, 5'd17, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'b011, 32'h33, 32'h44, 5'd18, 1'b0, 1'b0, 1'b0);
        idle(1'b1);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), a, b,
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 63) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
